// File: rtl/bcd_display_mux_pkg.sv
// bcd_display_mux_pkg: segment constants and digit patterns for the active-low 7-segment mux
package bcd_display_mux_pkg;
  typedef logic [6:0] seg_t;
  localparam logic SEG_ON = 1'b0;
  localparam logic ANODE_ON = 1'b0;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t DIGIT_SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
endpackage

// File: rtl/bcd_display_mux_bcd_to_7seg.sv
// bcd_to_7seg: 4-bit code to active-low {g..a} pattern, 'E' for codes 10-15
module bcd_to_7seg
  import bcd_display_mux_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg
);
  assign seg = code < 4'd10 ? DIGIT_SEG[code] : SEG_E;
endmodule

// File: rtl/bcd_display_mux.sv
// bcd_display_mux: snapshot a BCD count on latch and scan it onto a multiplexed 7-segment display
module bcd_display_mux
  import bcd_display_mux_pkg::*;
#(
  parameter int Ndigit = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*Ndigit-1:0] BCD,
  input  logic                overflow,
  input  logic                latch,
  input  logic                blank_lz,
  output logic [4*Ndigit-1:0] count_q,
  output logic                ovf_q,
  output logic [6:0]          seg,
  output logic [Ndigit-1:0]   anode
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = Ndigit > 1 ? $clog2(Ndigit) : 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic ovf_sticky, wrap, hi_zero;
  logic [3:0] digit;
  logic [4*Ndigit-1:0] hi;
  seg_t dec, seg_next;
  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  assign digit = count_q[{idx, 2'b00} +: 4];
  assign hi = count_q >> {idx, 2'b00};
  assign hi_zero = hi == '0;
  bcd_to_7seg u_dec (.code(digit), .seg(dec));
  always_comb begin
    seg_next = ovf_q ? SEG_DASH : (blank_lz && idx != '0 && hi_zero) ? SEG_BLANK : dec;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      ovf_sticky <= 1'b0;
      seg <= SEG_BLANK;
      anode <= {Ndigit{~ANODE_ON}};
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx == IW'(Ndigit - 1) ? '0 : idx + 1'b1;
      if (latch) begin
        count_q <= BCD;
        ovf_q <= ovf_sticky | overflow;
        ovf_sticky <= 1'b0;
      end else if (overflow) begin
        ovf_sticky <= 1'b1;
      end
      seg <= seg_next;
      anode <= ~(Ndigit'(1) << idx);
    end
  end
endmodule

// File: tb/tb_bcd_display_mux.sv
// tb_bcd_display_mux: randomized + directed scoreboard bench against a behavioural display model
module tb_bcd_display_mux;
  logic clk = 0, rst = 1, overflow = 0, latch = 0, blank_lz = 0;
  logic [15:0] BCD = '0, count_q;
  logic ovf_q;
  logic [6:0] seg;
  logic [3:0] anode;
  typedef struct {logic [15:0] c; logic o; logic [6:0] s; logic [3:0] a;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic [15:0] m_count = 0, bcd_v = 0;
  logic m_ovf = 0, m_sticky = 0, blz_v = 0;
  int tick = 0;
  logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  bcd_display_mux #(.Ndigit(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .BCD(BCD), .overflow(overflow), .latch(latch), .blank_lz(blank_lz),
    .count_q(count_q), .ovf_q(ovf_q), .seg(seg), .anode(anode)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] exp_seg(logic [15:0] c, logic o, logic b, int k);
    int d;
    d = (c >> (4 * k)) & 15;
    if (o) return 7'h3F;
    if (b && k > 0 && (c >> (4 * k)) == 0) return 7'h7F;
    if (d < 10) return tbl[d];
    return 7'h06;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic step(logic r, logic l, logic o);
    exp_t e;
    int k;
    @(negedge clk);
    rst = r; latch = l; overflow = o; BCD = bcd_v; blank_lz = blz_v;
    if (r) begin
      m_count = 0; m_ovf = 0; m_sticky = 0; tick = 0;
      e.s = 7'h7F; e.a = 4'hF;
    end else begin
      k = (tick / 4) % 4;
      e.s = exp_seg(m_count, m_ovf, blz_v, k);
      e.a = 4'hF & ~(4'b1 << k);
      if (l) begin
        m_count = bcd_v; m_ovf = m_sticky | o; m_sticky = 0;
      end else if (o) m_sticky = 1;
      tick++;
    end
    e.c = m_count; e.o = m_ovf;
    q.push_back(e);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("count_q", 32'(count_q), 32'(e.c));
      chk("ovf_q", 32'(ovf_q), 32'(e.o));
      chk("seg", 32'(seg), 32'(e.s));
      chk("anode", 32'(anode), 32'(e.a));
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end
  initial begin
    repeat (3) step(1, 0, 0);
    idle(6);
    bcd_v = 16'h1234; blz_v = 0; step(0, 1, 0); idle(20);
    bcd_v = 16'h0050; blz_v = 1; step(0, 1, 0); idle(20);
    bcd_v = 16'h0000; step(0, 1, 0); idle(20);
    bcd_v = 16'h0987; blz_v = 0; idle(3); step(0, 0, 1); idle(5); step(0, 1, 0); idle(16);
    step(0, 1, 0); idle(16);
    step(0, 1, 1); idle(10); step(0, 1, 0); idle(16);
    bcd_v = 16'h00A0; step(0, 1, 0); idle(16);
    idle(9); step(1, 0, 0); idle(10);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bcd_v = 16'($urandom);
      else if ($urandom_range(0, 7) == 0) bcd_v = 16'($urandom_range(0, 99));
      if ($urandom_range(0, 31) == 0) blz_v = ~blz_v;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
